// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core definitions: register address width, scoreboard clear-port
// indices, and the ID-stage instruction/decode structures.
package bsg_vanilla_pkg;

  localparam int reg_addr_width_gp = 5;

  typedef enum logic [0:0] {
    e_sb_clear_remote = 1'b0,
    e_sb_clear_idiv   = 1'b1
  } sb_clear_port_e;

  typedef struct packed {
    logic [6:0]                   funct7;
    logic [reg_addr_width_gp-1:0] rs2;
    logic [reg_addr_width_gp-1:0] rs1;
    logic [2:0]                   funct3;
    logic [reg_addr_width_gp-1:0] rd;
    logic [6:0]                   op;
  } instruction_s;

  typedef struct packed {
    logic read_rs1;
    logic read_rs2;
    logic write_rd;
    logic is_load_op;
    logic is_store_op;
    logic is_amo_op;
    logic is_idiv_op;
  } decode_s;

endpackage

// File: rtl/vanilla_scoreboard_clear_decode.sv
// Converts the writeback clear ports into a one-hot mask of effective clears and
// their count; flags stale clears and duplicate targets (later port is dropped).
module vanilla_scoreboard_clear_decode
  #(parameter int els_p                = 32,
    parameter int num_clear_port_p     = 2,
    parameter int lg_els_p             = 5,
    parameter int clear_count_width_p  = 2)
  (input  logic [num_clear_port_p-1:0]               clear_i,
   input  logic [num_clear_port_p-1:0][lg_els_p-1:0] clear_id_i,
   input  logic [els_p-1:0]                          pending_i,
   output logic [els_p-1:0]                          clear_mask_o,
   output logic [clear_count_width_p-1:0]            clear_count_o,
   output logic                                      dup_err_o,
   output logic                                      stale_err_o);

  logic [num_clear_port_p-1:0] dup_vec;
  logic [num_clear_port_p-1:0] stale_vec;
  logic [num_clear_port_p-1:0] hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < num_clear_port_p; gi++) begin : g_port
      logic dup_match;

      // A port is a duplicate if any lower-numbered active port names the same register.
      always_comb begin
        dup_match = 1'b0;
        for (int j = 0; j < gi; j++) begin
          if (clear_i[j] && (clear_id_i[j] == clear_id_i[gi])) dup_match = 1'b1;
        end
      end

      assign dup_vec[gi]   = clear_i[gi] & dup_match;
      assign stale_vec[gi] = clear_i[gi] & ~pending_i[clear_id_i[gi]];
      assign hit_vec[gi]   = clear_i[gi] & pending_i[clear_id_i[gi]] & ~dup_match;
    end
  endgenerate

  always_comb begin
    clear_mask_o  = '0;
    clear_count_o = '0;
    for (int k = 0; k < num_clear_port_p; k++) begin
      if (hit_vec[k]) begin
        clear_mask_o[clear_id_i[k]] = 1'b1;
        clear_count_o = clear_count_o + clear_count_width_p'(1);
      end
    end
  end

  assign dup_err_o   = |dup_vec;
  assign stale_err_o = |stale_vec;

endmodule

// File: rtl/vanilla_scoreboard.sv
// Integer-register scoreboard for the ID stage: RAW/WAW stall and outstanding-write count.
// Define VANILLA_SCOREBOARD_FORWARD_EN to let a same-cycle clear release the stall.
module vanilla_scoreboard
  import bsg_vanilla_pkg::*;
  #(parameter  int els_p            = 32,
    parameter  int num_clear_port_p = 2,
    localparam int lg_els_lp        = $clog2(els_p),
    localparam int count_width_lp   = $clog2(els_p + 1))
  (input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  instruction_s                               instruction_i,
   input  decode_s                                    decode_i,
   input  logic                                       score_i,
   input  logic [num_clear_port_p-1:0]                clear_i,
   input  logic [num_clear_port_p-1:0][lg_els_lp-1:0] clear_id_i,
   output logic                                       dependency_o,
   output logic [els_p-1:0]                           pending_o,
   output logic [count_width_lp-1:0]                  pending_count_o,
   output logic                                       empty_o);

  localparam int clear_count_width_lp = $clog2(num_clear_port_p + 1);

  logic [els_p-1:0]                pending_r, pending_next;
  logic [count_width_lp-1:0]       count_r, count_next;
  logic [els_p-1:0]                score_mask, clear_mask, pending_dep;
  logic [clear_count_width_lp-1:0] clear_count;
  logic                            dup_err, stale_err;
  logic                            score_eff;

  logic [lg_els_lp-1:0] rs1_idx, rs2_idx, rd_idx;
  assign rs1_idx = instruction_i.rs1[lg_els_lp-1:0];
  assign rs2_idx = instruction_i.rs2[lg_els_lp-1:0];
  assign rd_idx  = instruction_i.rd[lg_els_lp-1:0];

  vanilla_scoreboard_clear_decode #(
    .els_p               (els_p),
    .num_clear_port_p    (num_clear_port_p),
    .lg_els_p            (lg_els_lp),
    .clear_count_width_p (clear_count_width_lp)
  ) clear_decode (
    .clear_i       (clear_i),
    .clear_id_i    (clear_id_i),
    .pending_i     (pending_r),
    .clear_mask_o  (clear_mask),
    .clear_count_o (clear_count),
    .dup_err_o     (dup_err),
    .stale_err_o   (stale_err)
  );

  assign score_eff = score_i & (instruction_i.rd != '0);

  always_comb begin
    score_mask = '0;
    if (score_eff) score_mask[rd_idx] = 1'b1;
  end

  // Score is OR'd after the clear so a same-register score and clear leaves the bit set.
  assign pending_next = (pending_r & ~clear_mask) | score_mask;
  assign count_next   = count_r + count_width_lp'(score_eff) - count_width_lp'(clear_count);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r <= '0;
      count_r   <= '0;
    end else begin
      pending_r <= pending_next;
      count_r   <= count_next;
    end
  end

`ifdef VANILLA_SCOREBOARD_FORWARD_EN
  assign pending_dep = pending_r & ~clear_mask;
`else
  assign pending_dep = pending_r;
`endif

  assign dependency_o = (decode_i.read_rs1 & pending_dep[rs1_idx] & (instruction_i.rs1 != '0))
                      | (decode_i.read_rs2 & pending_dep[rs2_idx] & (instruction_i.rs2 != '0))
                      | (decode_i.write_rd & pending_dep[rd_idx]  & (instruction_i.rd  != '0));

  assign pending_o       = pending_r;
  assign pending_count_o = count_r;
  assign empty_o         = (count_r == '0);

  logic unused_fields;
  assign unused_fields = ^{instruction_i.funct7, instruction_i.funct3, instruction_i.op,
                           decode_i.is_load_op, decode_i.is_store_op,
                           decode_i.is_amo_op, decode_i.is_idiv_op};

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(score_i && dependency_o))
        else $error("vanilla_scoreboard: score issued while dependency is raised");
      assert (!dup_err)
        else $error("vanilla_scoreboard: two clear ports target the same register");
      assert (!stale_err)
        else $error("vanilla_scoreboard: clear of a register that is not pending");
    end
  end
`endif

endmodule

// File: tb/tb_vanilla_scoreboard.sv
// Directed self-checking bench for vanilla_scoreboard.
module tb_vanilla_scoreboard;
  import bsg_vanilla_pkg::*;

  localparam int els_lp = 32;
  localparam int ports_lp = 2;

`ifdef VANILLA_SCOREBOARD_FORWARD_EN
  localparam bit fwd_lp = 1'b1;
`else
  localparam bit fwd_lp = 1'b0;
`endif

  logic                             clk = 1'b0;
  logic                             reset_i;
  instruction_s                     instruction_i;
  decode_s                          decode_i;
  logic                             score_i;
  logic [ports_lp-1:0]              clear_i;
  logic [ports_lp-1:0][4:0]         clear_id_i;
  logic                             dependency_o;
  logic [els_lp-1:0]                pending_o;
  logic [5:0]                       pending_count_o;
  logic                             empty_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vanilla_scoreboard #(.els_p(els_lp), .num_clear_port_p(ports_lp)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .instruction_i   (instruction_i),
    .decode_i        (decode_i),
    .score_i         (score_i),
    .clear_i         (clear_i),
    .clear_id_i      (clear_id_i),
    .dependency_o    (dependency_o),
    .pending_o       (pending_o),
    .pending_count_o (pending_count_o),
    .empty_o         (empty_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("ok   %-22s = 0x%0h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    score_i       = 1'b0;
    clear_i       = '0;
    clear_id_i    = '0;
    instruction_i = '0;
    decode_i      = '0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic r1, input logic r2, input logic wd, input logic sc);
    instruction_i     = '0;
    instruction_i.rs1 = rs1;
    instruction_i.rs2 = rs2;
    instruction_i.rd  = rd;
    decode_i          = '0;
    decode_i.read_rs1 = r1;
    decode_i.read_rs2 = r2;
    decode_i.write_rd = wd;
    score_i           = sc;
  endtask

  task automatic set_clear(input int port, input logic [4:0] id);
    clear_i[port]    = 1'b1;
    clear_id_i[port] = id;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    check("reset_pending", 64'(pending_o), 64'h0);
    check("reset_count", 64'(pending_count_o), 64'd0);
    check("reset_empty", 64'(empty_o), 64'd1);
    check("reset_dep", 64'(dependency_o), 64'd0);

    // Score to x0 is never recorded.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("x0_dep", 64'(dependency_o), 64'd0);
    tick(); idle(); #1;
    check("x0_pending", 64'(pending_o), 64'h0);
    check("x0_empty", 64'(empty_o), 64'd1);

    // RAW on x5.
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("raw_score_dep", 64'(dependency_o), 64'd0);
    tick();
    drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("raw_dep", 64'(dependency_o), 64'd1);
    check("raw_pending", 64'(pending_o), 64'h20);
    check("raw_count", 64'(pending_count_o), 64'd1);
    check("raw_empty", 64'(empty_o), 64'd0);
    set_clear(0, 5'd5);
    #1;
    check("raw_clear_dep", 64'(dependency_o), fwd_lp ? 64'd0 : 64'd1);
    tick();
    clear_i = '0;
    #1;
    check("raw_after_dep", 64'(dependency_o), 64'd0);
    check("raw_after_pending", 64'(pending_o), 64'h0);
    check("raw_after_count", 64'(pending_count_o), 64'd0);

    // WAW on x7, cleared through the idiv port.
    idle();
    drive(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd2, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("waw_dep", 64'(dependency_o), 64'd1);
    check("waw_count", 64'(pending_count_o), 64'd1);
    tick();
    check("waw_dep_hold", 64'(dependency_o), 64'd1);
    check("waw_count_hold", 64'(pending_count_o), 64'd1);
    set_clear(e_sb_clear_idiv, 5'd7);
    #1;
    check("waw_clear_dep", 64'(dependency_o), fwd_lp ? 64'd0 : 64'd1);
    check("waw_clear_count", 64'(pending_count_o), 64'd1);
    tick();
    clear_i = '0;
    #1;
    check("waw_released_dep", 64'(dependency_o), 64'd0);
    check("waw_released_count", 64'(pending_count_o), 64'd0);

    // Score and clear of x9 in the same cycle.
    idle();
    drive(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    set_clear(e_sb_clear_remote, 5'd9);
    #1;
    check("simul_dep", 64'(dependency_o), 64'd0);
    check("simul_count_before", 64'(pending_count_o), 64'd1);
    tick(); idle(); #1;
    check("simul_pending", 64'(pending_o), 64'h200);
    check("simul_count", 64'(pending_count_o), 64'd1);
    check("simul_empty", 64'(empty_o), 64'd0);
    set_clear(0, 5'd9);
    tick(); idle(); #1;
    check("simul_cleanup_count", 64'(pending_count_o), 64'd0);

    // rs2 term only, and masking by read_rs2.
    drive(5'd0, 5'd0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd0, 5'd15, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("rs2_dep", 64'(dependency_o), 64'd1);
    decode_i.read_rs2 = 1'b0;
    #1;
    check("rs2_masked_dep", 64'(dependency_o), 64'd0);
    set_clear(0, 5'd15);
    tick(); idle(); #1;
    check("rs2_cleanup_count", 64'(pending_count_o), 64'd0);

    // Dual clear of x3 and x4 in one cycle.
    drive(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); idle(); #1;
    check("dual_pending", 64'(pending_o), 64'h18);
    check("dual_count", 64'(pending_count_o), 64'd2);
    set_clear(e_sb_clear_remote, 5'd3);
    set_clear(e_sb_clear_idiv, 5'd4);
    tick(); idle(); #1;
    check("dual_after_count", 64'(pending_count_o), 64'd0);
    check("dual_after_empty", 64'(empty_o), 64'd1);
    check("dual_after_pending", 64'(pending_o), 64'h0);

    // Reset mid-flight with a concurrent score and clear.
    drive(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); idle(); #1;
    check("mid_pending", 64'(pending_o), 64'h1C00);
    check("mid_count", 64'(pending_count_o), 64'd3);
    reset_i = 1'b1;
    drive(5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1);
    set_clear(0, 5'd10);
    tick();
    reset_i = 1'b0;
    idle();
    #1;
    check("mid_reset_pending", 64'(pending_o), 64'h0);
    check("mid_reset_count", 64'(pending_count_o), 64'd0);
    check("mid_reset_empty", 64'(empty_o), 64'd1);
    drive(5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("mid_reset_dep", 64'(dependency_o), 64'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
